ysyx_25040101_mc_ctrl: RTL

YSYX_25040101_MC_CTRL -- requirements
Module: ysyx_25040101_mc_ctrl

---
 rtl/ysyx_25040101_pkg.sv | 51 +++++
 rtl/ysyx_25040101_mc_ctrl_if.sv | 33 +++
 rtl/ysyx_25040101_ctrl_dec.sv | 70 +++++++
 rtl/ysyx_25040101_mc_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/ysyx_25040101_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, FSM states,
// immediate-select encodings and the decoder result payload.
package ysyx_25040101_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned IMM_W = 6;
  localparam int unsigned OPC_W = 7;

  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [XLEN-1:0] INST_EBREAK = 32'h0010_0073;

  // One-hot immediate selects; shamt reuses the I bit plus a marker bit.
  localparam logic [IMM_W-1:0] IMM_NONE  = 6'b000000;
  localparam logic [IMM_W-1:0] IMM_I     = 6'b100000;
  localparam logic [IMM_W-1:0] IMM_S     = 6'b010000;
  localparam logic [IMM_W-1:0] IMM_B     = 6'b001000;
  localparam logic [IMM_W-1:0] IMM_U     = 6'b000100;
  localparam logic [IMM_W-1:0] IMM_J     = 6'b000010;
  localparam logic [IMM_W-1:0] IMM_SHAMT = 6'b100001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEMORY,
    ST_WRITEBACK,
    ST_HALT
  } state_e;

  // Per-instruction control class produced by the decoder.
  typedef struct packed {
    logic [IMM_W-1:0] imm_type;
    logic             rf_we;
    logic             mem;
    logic             store;
    logic             legal;
    logic             ebreak;
  } dec_t;

endpackage

// File: rtl/ysyx_25040101_mc_ctrl_if.sv
// Core-side bus of the control unit: fetch handshake, data-memory handshake,
// instruction/immediate outputs, writeback strobes, status and counter.
// master: the control unit; slave: the surrounding datapath/memories.
interface ysyx_25040101_mc_ctrl_if;
  import ysyx_25040101_pkg::*;

  logic             ifu_req_o;
  logic             ifu_valid_i;
  logic [XLEN-1:0]  inst_i;
  logic [XLEN-1:0]  inst_o;
  logic [IMM_W-1:0] imm_type_o;
  logic             lsu_req_o;
  logic             lsu_we_o;
  logic             lsu_done_i;
  logic             rf_we_o;
  logic             pc_we_o;
  logic             halt_o;
  logic             illegal_o;
  logic [XLEN-1:0]  instret_o;

  modport master (
    output ifu_req_o, inst_o, imm_type_o, lsu_req_o, lsu_we_o,
           rf_we_o, pc_we_o, halt_o, illegal_o, instret_o,
    input  ifu_valid_i, inst_i, lsu_done_i
  );

  modport slave (
    input  ifu_req_o, inst_o, imm_type_o, lsu_req_o, lsu_we_o,
           rf_we_o, pc_we_o, halt_o, illegal_o, instret_o,
    output ifu_valid_i, inst_i, lsu_done_i
  );

endinterface

// File: rtl/ysyx_25040101_ctrl_dec.sv
// Combinational opcode-class decoder.
//   inst  : registered instruction word
//   dec_c : immediate select, rf-write class, memory class, store flag,
//           legality and ebreak detection
module ysyx_25040101_ctrl_dec
  import ysyx_25040101_pkg::*;
(
  input  logic [XLEN-1:0] inst,
  output dec_t            dec_c
);

  logic [OPC_W-1:0] opcode;
  logic [2:0]       funct3;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];

  always_comb begin
    dec_c = '0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        dec_c.imm_type = IMM_U;
        dec_c.rf_we    = 1'b1;
        dec_c.legal    = 1'b1;
      end
      OPC_JAL: begin
        dec_c.imm_type = IMM_J;
        dec_c.rf_we    = 1'b1;
        dec_c.legal    = 1'b1;
      end
      OPC_JALR: begin
        dec_c.imm_type = IMM_I;
        dec_c.rf_we    = 1'b1;
        dec_c.legal    = 1'b1;
      end
      OPC_LOAD: begin
        dec_c.imm_type = IMM_I;
        dec_c.rf_we    = 1'b1;
        dec_c.mem      = 1'b1;
        dec_c.legal    = 1'b1;
      end
      OPC_STORE: begin
        dec_c.imm_type = IMM_S;
        dec_c.mem      = 1'b1;
        dec_c.store    = 1'b1;
        dec_c.legal    = 1'b1;
      end
      OPC_BRANCH: begin
        dec_c.imm_type = IMM_B;
        dec_c.legal    = 1'b1;
      end
      OPC_OP_IMM: begin
        // slli/srli/srai carry a shift amount rather than a full immediate
        dec_c.imm_type = (funct3 == 3'b001 || funct3 == 3'b101) ? IMM_SHAMT : IMM_I;
        dec_c.rf_we    = 1'b1;
        dec_c.legal    = 1'b1;
      end
      OPC_OP: begin
        dec_c.rf_we = 1'b1;
        dec_c.legal = 1'b1;
      end
      OPC_SYSTEM: begin
        dec_c.legal  = 1'b1;
        dec_c.ebreak = (inst == INST_EBREAK);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_25040101_mc_ctrl.sv
// Multi-cycle control unit: Moore FSM sequencing fetch, decode, execute,
// memory and writeback, with the instruction register and retire counter.
//   clk, rst : clock and synchronous active-high reset
//   bus      : master side of the control bus (see interface)
// Strobes are registered from the next state so no input reaches them
// combinationally.
module ysyx_25040101_mc_ctrl
  import ysyx_25040101_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  ysyx_25040101_mc_ctrl_if.master     bus
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] instret_q, instret_d;
  logic            ifu_req_q, ifu_req_d;
  logic            lsu_req_q, lsu_req_d;
  logic            lsu_we_q, lsu_we_d;
  logic            rf_we_q, rf_we_d;
  logic            pc_we_q, pc_we_d;
  logic            halt_q, halt_d;
  logic            illegal_q, illegal_d;
  dec_t            dec_c;

  ysyx_25040101_ctrl_dec u_dec (
    .inst  (inst_q),
    .dec_c (dec_c)
  );

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      inst_q    <= '0;
      instret_q <= '0;
      ifu_req_q <= 1'b0;
      lsu_req_q <= 1'b0;
      lsu_we_q  <= 1'b0;
      rf_we_q   <= 1'b0;
      pc_we_q   <= 1'b0;
      halt_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      instret_q <= instret_d;
      ifu_req_q <= ifu_req_d;
      lsu_req_q <= lsu_req_d;
      lsu_we_q  <= lsu_we_d;
      rf_we_q   <= rf_we_d;
      pc_we_q   <= pc_we_d;
      halt_q    <= halt_d;
      illegal_q <= illegal_d;
    end
  end

  // Next state plus next values of the registered outputs.
  always_comb begin
    state_d   = state_q;
    inst_d    = inst_q;
    instret_d = instret_q;
    halt_d    = halt_q;
    illegal_d = illegal_q;

    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (bus.ifu_valid_i) begin
          inst_d  = bus.inst_i;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_c.ebreak) begin
          state_d = ST_HALT;
          halt_d  = 1'b1;
        end else if (!dec_c.legal) begin
          state_d   = ST_HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: state_d = dec_c.mem ? ST_MEMORY : ST_WRITEBACK;
      ST_MEMORY: begin
        if (bus.lsu_done_i) state_d = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        instret_d = instret_q + XLEN'(1);
        state_d   = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase

    // inst_q is stable from DECODE onward, so the class bits are valid here.
    ifu_req_d = (state_d == ST_FETCH);
    lsu_req_d = (state_d == ST_MEMORY);
    lsu_we_d  = (state_d == ST_MEMORY) && dec_c.store;
    rf_we_d   = (state_d == ST_WRITEBACK) && dec_c.rf_we;
    pc_we_d   = (state_d == ST_WRITEBACK);
  end

  assign bus.ifu_req_o  = ifu_req_q;
  assign bus.inst_o     = inst_q;
  assign bus.imm_type_o = dec_c.imm_type;
  assign bus.lsu_req_o  = lsu_req_q;
  assign bus.lsu_we_o   = lsu_we_q;
  assign bus.rf_we_o    = rf_we_q;
  assign bus.pc_we_o    = pc_we_q;
  assign bus.halt_o     = halt_q;
  assign bus.illegal_o  = illegal_q;
  assign bus.instret_o  = instret_q;

endmodule
